// File: rtl/ws2812_chain_if.sv
// CPU IO-bus register window of the WS2812 chain driver.
// The CPU side is the master; the chain driver is the slave.
interface ws2812_chain_if;
    logic       R_W_n;
    logic [2:0] reg_addr_i;
    logic [7:0] data_i;
    logic       led_cs;
    logic [7:0] data_o;

    modport master (
        output R_W_n,
        output reg_addr_i,
        output data_i,
        output led_cs,
        input  data_o
    );

    modport slave (
        input  R_W_n,
        input  reg_addr_i,
        input  data_i,
        input  led_cs,
        output data_o
    );
endinterface

// File: rtl/ws2812_chain.sv
// WS2812 chain driver: NUM_LEDS x 24-bit pixel buffer behind an index/colour
// register window, streamed GRB MSB-first on commit, followed by a latch gap.
module ws2812_chain #(
    parameter int NUM_LEDS = 8,
    parameter int CLK_FRE  = 25_175_000,
    parameter int LATCH_US = 60
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ws2812_chain_if.slave bus,
    output logic          ws2812
);
    localparam int KHZ    = CLK_FRE / 1000;
    localparam int T1H    = KHZ * 850 / 1_000_000;
    localparam int T1L    = KHZ * 400 / 1_000_000;
    localparam int T0H    = KHZ * 400 / 1_000_000;
    localparam int T0L    = KHZ * 850 / 1_000_000;
    localparam int LATCH  = KHZ * LATCH_US / 1000;
    localparam int T_BIT  = (T1H > T0L) ? T1H : T0L;
    localparam int T_MAX  = (LATCH > T_BIT) ? LATCH : T_BIT;
    localparam int CNT_W  = $clog2(T_MAX + 1);
    localparam int IDX_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    // Counters run from duration-1 down to zero, so each phase lasts exactly its duration.
    localparam logic [CNT_W-1:0] C_T1H   = CNT_W'(T1H - 1);
    localparam logic [CNT_W-1:0] C_T1L   = CNT_W'(T1L - 1);
    localparam logic [CNT_W-1:0] C_T0H   = CNT_W'(T0H - 1);
    localparam logic [CNT_W-1:0] C_T0L   = CNT_W'(T0L - 1);
    localparam logic [CNT_W-1:0] C_LATCH = CNT_W'(LATCH - 1);
    localparam logic [8:0]       NUM_W     = 9'(NUM_LEDS);
    localparam logic [IDX_W-1:0] LAST_PIX  = IDX_W'(NUM_LEDS - 1);
    localparam logic [7:0]       COUNT_VAL = 8'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] pixel_r;
    logic [4:0]       bit_r;
    logic [23:0]      shift_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             pending_r;
    logic             ws_r;
    logic [7:0]       index_r;
    logic             autoinc_r;
    logic [7:0]       r_mem [NUM_LEDS];
    logic [7:0]       g_mem [NUM_LEDS];
    logic [7:0]       b_mem [NUM_LEDS];

    logic             wr_s;
    logic             commit_s;
    logic             in_range_s;
    logic [IDX_W-1:0] idx_s;
    logic [7:0]       rd_data_s;

    assign wr_s       = bus.led_cs & ~bus.R_W_n;
    assign commit_s   = wr_s & (bus.reg_addr_i == 3'd4) & bus.data_i[0];
    assign in_range_s = ({1'b0, index_r} < NUM_W);
    assign idx_s      = index_r[IDX_W-1:0];

    // CPU writes: INDEX, AUTOINC and the pixel buffer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            index_r   <= 8'd0;
            autoinc_r <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_mem[i] <= 8'd0;
                g_mem[i] <= 8'd0;
                b_mem[i] <= 8'd0;
            end
        end else if (wr_s) begin
            case (bus.reg_addr_i)
                3'd0: index_r <= bus.data_i;
                3'd1: if (in_range_s) r_mem[idx_s] <= bus.data_i;
                3'd2: if (in_range_s) g_mem[idx_s] <= bus.data_i;
                3'd3: begin
                    if (in_range_s) begin
                        b_mem[idx_s] <= bus.data_i;
                        if (autoinc_r) begin
                            index_r <= (idx_s == LAST_PIX) ? 8'd0 : index_r + 8'd1;
                        end
                    end
                end
                3'd4: autoinc_r <= bus.data_i[1];
                default: ;
            endcase
        end
    end

    // Register read mux; out-of-range pixel reads return zero
    always_comb begin
        rd_data_s = 8'd0;
        case (bus.reg_addr_i)
            3'd0: rd_data_s = index_r;
            3'd1: if (in_range_s) rd_data_s = r_mem[idx_s]; else rd_data_s = 8'd0;
            3'd2: if (in_range_s) rd_data_s = g_mem[idx_s]; else rd_data_s = 8'd0;
            3'd3: if (in_range_s) rd_data_s = b_mem[idx_s]; else rd_data_s = 8'd0;
            3'd4: rd_data_s = {busy_r, pending_r, 5'd0, autoinc_r};
            3'd5: rd_data_s = COUNT_VAL;
            default: rd_data_s = 8'd0;
        endcase
    end

    assign bus.data_o = rd_data_s;
    assign ws2812     = ws_r;

    // Frame sequencer; the pin follows HIGH one cycle later from a register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= S_IDLE;
            pixel_r   <= '0;
            bit_r     <= 5'd0;
            shift_r   <= 24'd0;
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            pending_r <= 1'b0;
            ws_r      <= 1'b0;
        end else begin
            ws_r <= (state_r == S_HIGH);
            if (commit_s && busy_r) begin
                pending_r <= 1'b1;
            end
            case (state_r)
                S_IDLE: begin
                    if (commit_s) begin
                        state_r <= S_LOAD;
                        pixel_r <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    shift_r <= {g_mem[pixel_r], r_mem[pixel_r], b_mem[pixel_r]};
                    bit_r   <= 5'd23;
                    cnt_r   <= g_mem[pixel_r][7] ? C_T1H : C_T0H;
                    state_r <= S_HIGH;
                end
                S_HIGH: begin
                    if (cnt_r == '0) begin
                        state_r <= S_LOW;
                        cnt_r   <= shift_r[23] ? C_T1L : C_T0L;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                S_LOW: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else if (bit_r != 5'd0) begin
                        bit_r   <= bit_r - 5'd1;
                        shift_r <= {shift_r[22:0], 1'b0};
                        cnt_r   <= shift_r[22] ? C_T1H : C_T0H;
                        state_r <= S_HIGH;
                    end else if (pixel_r != LAST_PIX) begin
                        pixel_r <= pixel_r + IDX_W'(1);
                        state_r <= S_LOAD;
                    end else begin
                        cnt_r   <= C_LATCH;
                        state_r <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else if (pending_r || commit_s) begin
                        // A commit landing on the final latch cycle is served here too.
                        pending_r <= 1'b0;
                        pixel_r   <= '0;
                        state_r   <= S_LOAD;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812_chain.sv
// Self-checking bench for ws2812_chain: random register traffic against a
// register/buffer model, and frame waveforms decoded back into pixels.
`timescale 1ns/1ps
module tb_ws2812_chain;
    localparam int NL     = 2;
    localparam int T1H    = 21;
    localparam int T1L    = 10;
    localparam int T0H    = 10;
    localparam int T0L    = 21;
    localparam int TLATCH = 1510;

    logic clk_i = 1'b0;
    logic rst_i;
    logic ws2812;
    int   n_checks = 0;
    int   n_pass   = 0;

    ws2812_chain_if bus();

    ws2812_chain #(.NUM_LEDS(NL), .CLK_FRE(25_175_000), .LATCH_US(60)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus),
        .ws2812(ws2812)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: register file and pixel buffer
    int          m_idx;
    bit          m_auto;
    bit          m_busy;
    bit          m_pend;
    logic [7:0]  m_r [NL];
    logic [7:0]  m_g [NL];
    logic [7:0]  m_b [NL];
    logic [23:0] exp_frame [NL];

    task automatic model_reset();
        m_idx = 0; m_auto = 1'b0; m_busy = 1'b0; m_pend = 1'b0;
        for (int i = 0; i < NL; i++) begin
            m_r[i] = 8'd0; m_g[i] = 8'd0; m_b[i] = 8'd0;
        end
    endtask

    function automatic logic [7:0] model_read(input logic [2:0] a);
        bit ok = (m_idx < NL);
        case (a)
            3'd0: return 8'(m_idx);
            3'd1: return ok ? m_r[m_idx] : 8'd0;
            3'd2: return ok ? m_g[m_idx] : 8'd0;
            3'd3: return ok ? m_b[m_idx] : 8'd0;
            3'd4: return {m_busy, m_pend, 5'd0, m_auto};
            3'd5: return 8'(NL - 1);
            default: return 8'd0;
        endcase
    endfunction

    task automatic model_write(input logic [2:0] a, input logic [7:0] d);
        bit ok = (m_idx < NL);
        case (a)
            3'd0: m_idx = int'(d);
            3'd1: if (ok) m_r[m_idx] = d;
            3'd2: if (ok) m_g[m_idx] = d;
            3'd3: if (ok) begin
                m_b[m_idx] = d;
                if (m_auto) m_idx = (m_idx + 1) % NL;
            end
            3'd4: m_auto = d[1];
            default: ;
        endcase
    endtask

    function automatic logic [23:0] model_pixel(input int p);
        return {m_g[p], m_r[p], m_b[p]};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk_i);
        bus.led_cs = 1'b1; bus.R_W_n = 1'b0; bus.reg_addr_i = a; bus.data_i = d;
        @(posedge clk_i);
        #1;
        bus.led_cs = 1'b0; bus.R_W_n = 1'b1; bus.reg_addr_i = 3'd4;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus_wr(a, d);
        model_write(a, d);
    endtask

    task automatic rd_chk(input logic [2:0] a, input string tag);
        logic [7:0] v;
        @(negedge clk_i);
        bus.reg_addr_i = a;
        #1 v = bus.data_o;
        chk(tag, int'(v), int'(model_read(a)));
        bus.reg_addr_i = 3'd4;
    endtask

    task automatic start_frame(input string tag);
        int n = 0;
        bus_wr(3'd4, {6'd0, m_auto, 1'b1});
        m_busy = 1'b1;
        chk({tag, "_ctrl"}, int'(bus.data_o), int'(model_read(3'd4)));
        while (ws2812 !== 1'b1 && n < 50) begin @(negedge clk_i); n++; end
        chk({tag, "_latency"}, n, 3);
    endtask

    // Decode one frame from the pin; entered at the negedge where the first bit has risen
    task automatic capture(input bit to_next);
        for (int p = 0; p < NL; p++) begin
            logic [23:0] got;
            got = 24'd0;
            for (int b = 23; b >= 0; b--) begin
                int h = 0;
                int l = 0;
                int exp_l;
                bit e = exp_frame[p][b];
                while (ws2812 === 1'b1 && h < 200) begin @(negedge clk_i); h++; end
                got[b] = (h > 15);
                chk("t_high", h, e ? T1H : T0H);
                exp_l = e ? T1L : T0L;
                if (b > 0 || p < NL - 1) begin
                    if (b == 0) exp_l++;
                    while (ws2812 === 1'b0 && l < 200) begin @(negedge clk_i); l++; end
                    chk("t_low", l, exp_l);
                end else if (to_next) begin
                    while (ws2812 === 1'b0 && l < 5000) begin @(negedge clk_i); l++; end
                    chk("frame_gap", l, exp_l + TLATCH + 1);
                end else begin
                    while (bus.data_o[7] === 1'b1 && l < 5000) begin @(negedge clk_i); l++; end
                    chk("latch_to_idle", l, exp_l + TLATCH - 1);
                    chk("idle_ws", int'(ws2812), 0);
                end
            end
            chk("pixel", int'(got), int'(exp_frame[p]));
        end
    endtask

    task automatic snap_expected();
        for (int p = 0; p < NL; p++) exp_frame[p] = model_pixel(p);
    endtask

    task automatic full_frame(input string tag);
        snap_expected();
        start_frame(tag);
        capture(1'b0);
        m_busy = 1'b0;
        rd_chk(3'd4, {tag, "_done_ctrl"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int rises;
        bus.led_cs = 1'b0; bus.R_W_n = 1'b1; bus.reg_addr_i = 3'd4; bus.data_i = 8'd0;
        rst_i = 1'b1;
        model_reset();
        repeat (4) @(posedge clk_i);
        @(negedge clk_i) rst_i = 1'b0;
        chk("rst_ws", int'(ws2812), 0);
        for (int a = 0; a < 8; a++) rd_chk(3'(a), "rst_reg");

        // Directed pixel pattern from the data sheet example
        wr(3'd0, 8'd0); wr(3'd1, 8'h80); wr(3'd2, 8'h01); wr(3'd3, 8'hFF);
        chk("pix0_model", int'(model_pixel(0)), 24'h0180FF);
        full_frame("f1");

        // Auto-increment wraps from the last pixel to 0
        wr(3'd4, 8'h02);
        wr(3'd0, 8'(NL - 1)); wr(3'd1, 8'h11); wr(3'd2, 8'h22); wr(3'd3, 8'h33);
        rd_chk(3'd0, "autoinc_wrap");
        wr(3'd0, 8'(NL - 1));
        rd_chk(3'd1, "last_r"); rd_chk(3'd2, "last_g"); rd_chk(3'd3, "last_b");

        // Out-of-range INDEX: writes dropped, reads zero, INDEX not incremented
        wr(3'd0, 8'(NL)); wr(3'd1, 8'h55); wr(3'd3, 8'hAA);
        rd_chk(3'd1, "oor_r"); rd_chk(3'd0, "oor_idx");

        // Random register traffic
        for (int k = 0; k < 40; k++) begin
            logic [2:0] a;
            logic [7:0] d;
            a = 3'($urandom_range(0, 7));
            d = 8'($urandom_range(0, 255));
            if (a == 3'd0) d = 8'($urandom_range(0, NL + 1));
            if (a == 3'd4) d[0] = 1'b0;
            wr(a, d);
            rd_chk(3'($urandom_range(0, 7)), "rand_rd");
        end
        full_frame("f_rand");

        // Two commits during a frame give exactly two back-to-back frames
        snap_expected();
        start_frame("b2b");
        fork
            begin
                repeat (20) @(negedge clk_i);
                bus_wr(3'd4, {6'd0, m_auto, 1'b1});
                bus_wr(3'd4, {6'd0, m_auto, 1'b1});
                m_pend = 1'b1;
                rd_chk(3'd4, "pend_set");
            end
            capture(1'b1);
        join
        m_pend = 1'b0;
        chk("pend_clr", int'(bus.data_o), int'(model_read(3'd4)));
        capture(1'b0);
        m_busy = 1'b0;
        rises = 0;
        for (int c = 0; c < 200; c++) begin @(negedge clk_i); if (ws2812 === 1'b1) rises++; end
        chk("no_third_frame", rises, 0);

        // Mid-frame update: pixel 0 already loaded keeps old data, last pixel takes new
        begin
            logic [7:0] n0 [3];
            logic [7:0] nl [3];
            for (int i = 0; i < 3; i++) begin
                n0[i] = 8'($urandom_range(0, 255));
                nl[i] = 8'($urandom_range(0, 255));
            end
            snap_expected();
            exp_frame[NL - 1] = {nl[1], nl[0], nl[2]};
            start_frame("mid");
            fork
                begin
                    repeat (100) @(negedge clk_i);
                    wr(3'd0, 8'd0);
                    wr(3'd1, n0[0]); wr(3'd2, n0[1]); wr(3'd3, n0[2]);
                    wr(3'd0, 8'(NL - 1));
                    wr(3'd1, nl[0]); wr(3'd2, nl[1]); wr(3'd3, nl[2]);
                end
                capture(1'b0);
            join
            m_busy = 1'b0;
            chk("mid_pix0_new", int'(model_pixel(0)), int'({n0[1], n0[0], n0[2]}));
        end
        full_frame("f_after_mid");

        // Reset while the pin is high aborts the frame
        snap_expected();
        start_frame("rst_mid");
        repeat (40) @(negedge clk_i);
        begin
            int n = 0;
            while (ws2812 !== 1'b1 && n < 100) begin @(negedge clk_i); n++; end
            chk("rst_mid_found_high", int'(ws2812), 1);
        end
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 chk("rst_mid_ws", int'(ws2812), 0);
        @(negedge clk_i) rst_i = 1'b0;
        model_reset();
        rd_chk(3'd4, "rst_mid_ctrl");
        rd_chk(3'd0, "rst_mid_idx");
        for (int i = 0; i < NL; i++) begin
            wr(3'd0, 8'(i));
            rd_chk(3'd1, "rst_mid_r"); rd_chk(3'd2, "rst_mid_g"); rd_chk(3'd3, "rst_mid_b");
        end
        rises = 0;
        for (int c = 0; c < 300; c++) begin @(negedge clk_i); if (ws2812 === 1'b1) rises++; end
        chk("rst_no_resume", rises, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ws2812_chain.md
# ws2812_chain

Parametrised WS2812 chain driver on the CPU IO bus, successor to the single-pixel LED/WS2812 core. Holds a NUM_LEDS-deep 24-bit pixel buffer written through an index/colour register window, and on a commit streams the whole chain (GRB, MSB first) followed by a latch gap. It supports mid-frame buffer updates, commit queuing while busy, and a busy status. It sits beside the LED core in the IO page and drives one FPGA pin.

## Interface
- NUM_LEDS, 8: pixels in chain, 1..256
- CLK_FRE, 25_175_000: clk_i frequency in Hz
- LATCH_US, 60: low time after the frame, in µs (≥50)
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- R_W_n  in  1  1 = read, 0 = write
- reg_addr_i  in  3  register select
- data_i  in  8  write data
- led_cs  in  1  chip select; a write occurs on each clk_i edge with led_cs=1 and R_W_n=0
- data_o  out  8  read data, combinational from reg_addr_i
- ws2812  out  1  serial data to chain, registered

## Operation
- Registers:
  - 0 INDEX (rw), 8 bits.
  - 1 R, 2 G, 3 B (rw): access buffer[INDEX].
  - 4 CTRL: write bit0=1 commits; bit1 = AUTOINC (stored); read {busy,pending,5'b0,AUTOINC}.
  - 5 COUNT (ro) = NUM_LEDS-1.
  - 6,7 read 0; writes are ignored.
- INDEX ≥ NUM_LEDS: R/G/B writes are discarded and R/G/B reads return 0.
- Auto-increment: after a B write with AUTOINC=1, INDEX+1. The value NUM_LEDS-1 wraps to 0. An out-of-range INDEX is unchanged.
- Cycle counts use integer truncation: C = CLK_FRE/1000*ns/1_000_000.
  - T1H = 850 ns, T1L = 400 ns, T0H = 400 ns, T0L = 850 ns.
  - At the default clock: T1H=21, T1L=10, T0H=10, T0L=21.
  - LATCH = CLK_FRE/1000*LATCH_US/1000 = 1510.
  - Counter width ≥ clog2(LATCH+1).
- State machine: IDLE, LOAD, HIGH, LOW, LATCH.
  - IDLE: ws2812=0. Commit → LOAD, pixel=0, busy=1.
  - LOAD: shift reg ← {G,R,B} of buffer[pixel], bit=23 → HIGH. The snapshot happens here: writes to pixels already loaded do not affect the current frame; writes to later pixels do.
  - HIGH: ws2812=1 for T1H/T0H cycles → LOW.
  - LOW: ws2812=0 for T1L/T0L cycles. Then:
    - bit>0: bit-1 → HIGH.
    - else if pixel<NUM_LEDS-1: pixel+1 → LOAD.
    - else → LATCH.
  - LATCH: ws2812=0 for LATCH cycles. Then pending=1 → clear pending, LOAD with pixel=0; else → IDLE with busy=0.
- Commit while busy sets pending, a single-deep queue; further commits are absorbed. A commit in the final LATCH cycle is also queued and is not lost.
- A CPU write and a LOAD read of the same pixel on the same edge: LOAD captures the old value.
- Reset: ws2812=0, state IDLE, busy=0, pending=0, INDEX=0, AUTOINC=0, all buffer entries 0, counters 0. Reset mid-frame aborts immediately with ws2812 low on the next edge. No partial frame resumes.

## Timing
- The commit write is sampled at edge N. Then busy=1 and state=LOAD after N, HIGH after N+1, and ws2812 rises at N+2.
- LOAD is one cycle. It adds 1 cycle to the low phase of the last bit of each pixel before the next pixel, except the last pixel. This is within WS2812 tolerance.
- Frame duration: NUM_LEDS*24 bit periods plus NUM_LEDS LOAD cycles plus LATCH cycles.
- busy falls on the edge that leaves LATCH to IDLE.
- data_o is combinational. It reflects the buffer in the same cycle a write completes, i.e. the next cycle after the edge.

## Test plan
- Reset: assert rst_i mid-stream → next cycle ws2812=0, CTRL reads 0x00, INDEX=0, all R/G/B read 0.
- NUM_LEDS=2, default clock:
  - Stimulus: INDEX=0, R=0x80, G=0x01, B=0xFF, commit.
  - Required response: first 24 bits decode to G=0x01, R=0x80, B=0xFF (MSB first), then 24 zero bits.
  - Pulse widths: 1-bit high 21 cycles, 0-bit high 10 cycles.
  - Then 1510 low cycles; busy falls after the final low.
- AUTOINC=1, INDEX=NUM_LEDS-1, write R,G,B → INDEX reads 0; buffer[NUM_LEDS-1] holds the values.
- Commit twice during a frame → exactly two frames back-to-back, separated by one LATCH; pending clears at the second LOAD.
- INDEX=NUM_LEDS, write R=0x55 → read R=0; buffer unchanged; the next frame carries the original data.
- During frame, write pixel 0 (already sent) and pixel NUM_LEDS-1 (not yet loaded) → the frame shows the old pixel 0 and the new last pixel.
